// File: rtl/img_pkg.sv
// Shared defaults and types for the image reader.
package img_pkg;

  localparam int DEF_IMG_WIDTH  = 41;
  localparam int DEF_IMG_HEIGHT = 50;
  localparam int DEF_SWEEP_X    = 25;
  localparam int DEF_SWEEP_Y    = 25;
  localparam int DEF_PIX_W      = 8;

  // Accepted coordinates that have not yet left the block (RAM read plus queued pixels).
  localparam int FIFO_DEPTH     = 3;

  // One output FIFO entry: the window-last marker travels with its pixel.
  typedef struct packed {
    logic                 last;
    logic [DEF_PIX_W-1:0] data;
  } pix_entry_t;

  // Number of pixels in one sweep window.
  function automatic int win_pixels(input int sx, input int sy);
    return sx * sy;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO with a registered occupancy count.
module sync_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage slots: data only, no reset needed since occupancy guards every read.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_q == PW'(gi)))
        mem_q[gi] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/img_reader.sv
// Turns a stream of window coordinates into a stream of pixels read from the image RAM.
module img_reader import img_pkg::*; #(
  parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter  int SWEEP_X    = DEF_SWEEP_X,
  parameter  int SWEEP_Y    = DEF_SWEEP_Y,
  parameter  int PIX_W      = DEF_PIX_W,
  localparam int W_X        = $clog2(IMG_WIDTH),
  localparam int W_Y        = $clog2(IMG_HEIGHT),
  localparam int W_A        = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             addr_valid,
  output logic             addr_ready,
  input  logic [W_X-1:0]   x,
  input  logic [W_Y-1:0]   y,
  output logic             mem_rd_en,
  output logic [W_A-1:0]   mem_addr,
  input  logic [PIX_W-1:0] mem_rd_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_last,
  output logic             range_err
);

  localparam int WIN_PIX  = win_pixels(SWEEP_X, SWEEP_Y);
  localparam int W_C      = (WIN_PIX > 1) ? $clog2(WIN_PIX) : 1;
  localparam int CW       = $clog2(FIFO_DEPTH + 1);
  localparam int EW       = PIX_W + 1;
  localparam logic [W_C-1:0] LAST_IDX = W_C'(WIN_PIX - 1);

  logic           run_q;
  logic           inflight_q;
  logic           last_q;
  logic [W_C-1:0] pix_cnt_q, pix_cnt_d;
  logic           range_err_q;
  logic           hs;
  logic           in_range;
  logic [W_A-1:0] lin_addr;
  logic [CW:0]    occupancy;
  logic [CW-1:0]  fifo_cnt;
  logic           fifo_empty;
  logic [EW-1:0]  fifo_head;
  logic           pop;

  // Accept only while every accepted coordinate is guaranteed a FIFO slot; built
  // purely from registers so downstream backpressure never ripples upstream.
  assign occupancy  = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight_q};
  assign addr_ready = run_q & (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign hs         = addr_valid & addr_ready;

  // Linear address; out-of-image coordinates still read, but from word 0.
  assign in_range   = (int'(x) < IMG_WIDTH) && (int'(y) < IMG_HEIGHT);
  assign lin_addr   = W_A'(y) * W_A'(IMG_WIDTH) + W_A'(x);
  assign mem_rd_en  = hs;
  assign mem_addr   = (hs && in_range) ? lin_addr : '0;

  assign pix_cnt_d  = (pix_cnt_q == LAST_IDX) ? '0 : pix_cnt_q + 1'b1;

  // Handshake bookkeeping: read-in-flight flag, window position, sticky range error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q       <= 1'b0;
      inflight_q  <= 1'b0;
      last_q      <= 1'b0;
      pix_cnt_q   <= '0;
      range_err_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= hs;
      if (hs) begin
        last_q    <= (pix_cnt_q == LAST_IDX);
        pix_cnt_q <= pix_cnt_d;
        if (!in_range) range_err_q <= 1'b1;
      end
    end
  end

  assign range_err = range_err_q;

  // RAM data lands one cycle after the strobe and is queued with its last marker.
  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .data_i  ({last_q, mem_rd_data}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  // Output side is the FIFO head, forced to zero while nothing is queued.
  assign pix_valid = ~fifo_empty;
  assign pop       = pix_valid & pix_ready;
  assign pix_data  = pix_valid ? fifo_head[PIX_W-1:0] : '0;
  assign pix_last  = pix_valid & fifo_head[PIX_W];

endmodule

// File: tb/tb_img_reader.sv
// Randomised bench for img_reader with a transaction-level reference model.
module tb_img_reader;
  import img_pkg::*;

  localparam int IW = 41;
  localparam int IH = 50;
  localparam int WP = 625;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        addr_valid = 1'b0;
  logic        addr_ready;
  logic [5:0]  x = '0;
  logic [5:0]  y = '0;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rd_data = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [7:0]  pix_data;
  logic        pix_last;
  logic        range_err;

  img_reader dut (
    .clk         (clk),
    .rst         (rst),
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .x           (x),
    .y           (y),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .range_err   (range_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Image RAM: one-cycle read latency.
  logic [7:0] ram [0:4095];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  // Reference model: every accepted coordinate becomes exactly one pixel,
  // delivered in order, no earlier than two cycles after acceptance.
  typedef struct {
    pix_entry_t e;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   hs_total = 0;     // handshakes since last reset
  int   hs_count = 0;     // handshakes over the whole run
  int   pop_idx = 0;
  int   edges = 0;        // clock edges seen since reset released
  bit   range_model = 0;
  logic hs_m, exp_v;
  exp_t ent;

  function automatic int model_addr(input int xx, input int yy);
    return (xx < IW && yy < IH) ? yy * IW + xx : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) edges = 0;
    else     edges++;
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_addr_ready", addr_ready, 0);
      chk("rst_mem_rd_en",  mem_rd_en, 0);
      chk("rst_pix_valid",  pix_valid, 0);
      chk("rst_pix_last",   pix_last, 0);
      chk("rst_pix_data",   pix_data, 0);
      chk("rst_range_err",  range_err, 0);
      exp_q.delete();
      hs_total    = 0;
      range_model = 0;
    end else begin
      chk("addr_ready", addr_ready, (edges > 0 && exp_q.size() < 3));
      hs_m = addr_valid && addr_ready;
      chk("mem_rd_en", mem_rd_en, hs_m);
      if (hs_m) chk("mem_addr", mem_addr, model_addr(int'(x), int'(y)));
      chk("range_err", range_err, range_model);
      exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
      chk("pix_valid", pix_valid, exp_v);
      if (exp_v) begin
        chk("pix_data", pix_data, exp_q[0].e.data);
        chk("pix_last", pix_last, exp_q[0].e.last);
        if (pix_ready) begin
          $display("pix %0d data=%02h last=%0b", pop_idx, pix_data, pix_last);
          pop_idx++;
          void'(exp_q.pop_front());
        end
      end
      if (hs_m) begin
        ent.e.data = ram[model_addr(int'(x), int'(y))];
        ent.e.last = ((hs_total % WP) == WP - 1);
        ent.acc    = cyc;
        exp_q.push_back(ent);
        hs_total++;
        hs_count++;
        if (int'(x) >= IW || int'(y) >= IH) range_model = 1;
      end
    end
    cyc++;
  end

  // Present one coordinate until accepted; valid/ready are randomised per cycle.
  task automatic send(input logic [5:0] xx, input logic [5:0] yy,
                      input int ready_pct, input int idle_pct);
    bit acc = 0;
    int guard = 0;
    x = xx;
    y = yy;
    while (!acc && guard < 4000) begin
      addr_valid = ($urandom_range(99) >= idle_pct);
      pix_ready  = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      acc = addr_valid && addr_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    addr_valid = 1'b0;
    chk("send_accept", 32'(acc), 1);
  endtask

  task automatic idle(input int n, input bit r);
    addr_valid = 1'b0;
    pix_ready  = r;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rand(input int ready_pct, input int idle_pct, input int oob_pct);
    logic [5:0] xx, yy;
    xx = 6'($urandom_range(IW - 1));
    yy = 6'($urandom_range(IH - 1));
    if ($urandom_range(99) < oob_pct) xx = 6'($urandom_range(63, IW));
    send(xx, yy, ready_pct, idle_pct);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit acc;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[85] = 8'hA5;

    // Reset, then release just after an edge.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single coordinate x=3,y=2 -> word 85, pixel two cycles later for one cycle.
    send(6'd3, 6'd2, 100, 0);
    pix_ready = 1'b1;
    @(negedge clk);
    chk("single_n1_valid", pix_valid, 0);
    @(negedge clk);
    chk("single_n2_valid", pix_valid, 1);
    chk("single_n2_data", pix_data, 8'hA5);
    @(negedge clk);
    chk("single_n3_valid", pix_valid, 0);
    @(posedge clk);
    #1;

    // Back-to-back stream with the sink always ready.
    for (int i = 0; i < WP + 1; i++) send_rand(100, 0, 0);
    idle(5, 1'b1);

    // Sink stalled for 10 cycles: only three coordinates may be accepted.
    base = hs_count;
    pix_ready  = 1'b0;
    addr_valid = 1'b1;
    x = 6'($urandom_range(IW - 1));
    y = 6'($urandom_range(IH - 1));
    repeat (10) begin
      @(negedge clk);
      acc = addr_valid && addr_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        x = 6'($urandom_range(IW - 1));
        y = 6'($urandom_range(IH - 1));
      end
    end
    chk("bp_handshakes", hs_count - base, 3);
    chk("bp_ready_low", addr_ready, 0);
    chk("bp_valid_held", pix_valid, 1);
    addr_valid = 1'b0;
    for (int i = 0; i < 20; i++) send_rand(100, 0, 0);
    idle(5, 1'b1);

    // Out-of-image coordinate, then sticky flag through 100 normal ones.
    send(6'd41, 6'd0, 100, 0);
    for (int i = 0; i < 100; i++) send_rand(100, 0, 0);
    chk("range_err_held", range_err, 1);
    idle(5, 1'b1);

    // Reset with two pixels queued and one read in flight.
    for (int i = 0; i < 3; i++) send_rand(0, 0, 0);
    chk("pre_rst_valid", pix_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", pix_valid, 0);
    chk("async_rst_ready", addr_ready, 0);
    chk("async_rst_range", range_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < WP + 1; i++) send_rand(100, 0, 0);
    idle(5, 1'b1);

    // Random traffic on both sides, occasional out-of-image columns.
    for (int i = 0; i < 5000; i++) send_rand(50, 50, 3);
    idle(10, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", pix_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
